butterfly_sched: RTL and testbench

//  Layer/address scheduler for the shared butterfly path (modular multiplier + adder stage).

---
 rtl/butterfly_sched.sv | 179 +++++++++++++++++
 tb/tb_butterfly_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/butterfly_sched.sv
// Layer/address scheduler for the shared NTT/INTT butterfly path: issues one butterfly
// read per cycle, drains the datapath between layers and replays the addresses as write-backs.
module butterfly_sched #(
  parameter int PIPE_LAT = 7,
  parameter int N_BFLY   = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic [2:0] layer,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] tw_idx,
  output logic [1:0] sel_a,
  output logic       adder_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int KW = $clog2(N_BFLY);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_BFLY - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [2:0]    layer_q, layer_d;
  logic          mode_q, mode_d;
  logic          inv_q, inv_d;
  logic [2:0]    shift_d;
  logic [7:0]    addr_a_d, addr_b_d, tw_d;

  logic          busy_q, done_q, rd_en_q;
  logic [7:0]    rd_a_q, rd_b_q, tw_q;
  logic          wen_pipe_q [PIPE_LAT];
  logic [7:0]    wa_pipe_q  [PIPE_LAT];
  logic [7:0]    wb_pipe_q  [PIPE_LAT];

  // Upper address: group g occupies 2L slots, j is the offset inside the group.
  function automatic logic [7:0] addr_a_f(input logic [KW-1:0] k, input logic [2:0] s);
    logic [7:0] kk, span, g;
    kk   = 8'(k);
    span = 8'd1 << s;
    g    = kk >> s;
    return ((g << s) << 1) | (kk & (span - 8'd1));
  endfunction

  function automatic logic [7:0] tw_f(input logic [KW-1:0] k, input logic [2:0] s,
                                      input logic iv);
    logic [8:0] t;
    logic [7:0] g;
    g = 8'(k) >> s;
    if (iv) t = (9'd256 >> s) - 9'd1 - {1'b0, g};
    else    t = {1'b0, (8'd128 >> s) + g};
    return t[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    layer_d = layer_q;
    mode_d  = mode_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          k_d     = '0;
          layer_d = 3'd0;
          mode_d  = mode;
          inv_d   = inv;
        end
      end
      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (layer_q == (mode_q ? 3'd7 : 3'd6)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // log2 of the span: NTT shrinks from 128, INTT grows from 2 (Kyber) or 1 (Dilithium).
  always_comb begin
    shift_d  = inv_d ? (layer_d + {2'b00, ~mode_d}) : (3'd7 - layer_d);
    addr_a_d = addr_a_f(k_d, shift_d);
    addr_b_d = addr_a_d + (8'd1 << shift_d);
    tw_d     = tw_f(k_d, shift_d, inv_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
      layer_q <= 3'd0;
      mode_q  <= 1'b0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= 8'd0;
      rd_b_q  <= 8'd0;
      tw_q    <= 8'd0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wen_pipe_q[i] <= 1'b0;
        wa_pipe_q[i]  <= 8'd0;
        wb_pipe_q[i]  <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      layer_q <= layer_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
      busy_q  <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_FIN);
      rd_en_q <= (state_d == S_ISSUE);
      if (state_d == S_ISSUE) begin
        rd_a_q <= addr_a_d;
        rd_b_q <= addr_b_d;
        tw_q   <= tw_d;
      end
      // Write-back replay: stage 0 holds the read issued one cycle ago.
      wen_pipe_q[0] <= rd_en_q;
      wa_pipe_q[0]  <= rd_a_q;
      wb_pipe_q[0]  <= rd_b_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wen_pipe_q[i] <= wen_pipe_q[i-1];
        wa_pipe_q[i]  <= wa_pipe_q[i-1];
        wb_pipe_q[i]  <= wb_pipe_q[i-1];
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign layer      = layer_q;
  assign rd_en      = rd_en_q;
  assign rd_addr_a  = rd_a_q;
  assign rd_addr_b  = rd_b_q;
  assign tw_idx     = tw_q;
  assign sel_a      = {inv_q, 1'b0};
  assign adder_mode = mode_q;
  assign wr_en      = wen_pipe_q[PIPE_LAT-1];
  assign wr_addr_a  = wa_pipe_q[PIPE_LAT-1];
  assign wr_addr_b  = wb_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_butterfly_sched.sv
// Directed bench for butterfly_sched: address/twiddle vectors, run lengths, write-back
// alignment, start filtering and asynchronous abort.
module tb_butterfly_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       inv = 1'b0;
  logic       busy, done, rd_en, adder_mode, wr_en;
  logic [2:0] layer;
  logic [7:0] rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b;
  logic [1:0] sel_a;

  butterfly_sched dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .inv(inv),
    .busy(busy), .done(done), .layer(layer), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .sel_a(sel_a), .adder_mode(adder_mode), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: log every read issue, count writes/done, and compare each write
  // against the read seen exactly 7 cycles earlier.
  int cyc = 0, nrd = 0, nwr = 0, ndone = 0, t_done = 0, align_err = 0;
  int rec_a [8192];
  int rec_b [8192];
  int rec_tw[8192];
  int rec_l [8192];
  int rec_t [8192];
  bit       ring_en [8];
  bit [7:0] ring_a  [8];
  bit [7:0] ring_b  [8];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        ring_en[i] <= 1'b0;
        ring_a[i]  <= 8'd0;
        ring_b[i]  <= 8'd0;
      end
    end else begin
      if (wr_en != ring_en[(cyc + 1) % 8] ||
          (wr_en && (wr_addr_a != ring_a[(cyc + 1) % 8] || wr_addr_b != ring_b[(cyc + 1) % 8])))
        align_err <= align_err + 1;
      ring_en[cyc % 8] <= rd_en;
      ring_a[cyc % 8]  <= rd_addr_a;
      ring_b[cyc % 8]  <= rd_addr_b;
    end
    if (rd_en && nrd < 8192) begin
      rec_a[nrd]  <= int'(rd_addr_a);
      rec_b[nrd]  <= int'(rd_addr_b);
      rec_tw[nrd] <= int'(tw_idx);
      rec_l[nrd]  <= int'(layer);
      rec_t[nrd]  <= cyc;
      nrd <= nrd + 1;
    end
    if (wr_en) nwr <= nwr + 1;
    if (done) begin
      ndone  <= ndone + 1;
      t_done <= cyc;
    end
  end

  task automatic run_xform(input logic m, input logic iv, input bit poke_mid,
                           input bit poke_fin, output int b, output int bw, output int bd);
    int guard;
    b = nrd; bw = nwr; bd = ndone;
    @(negedge clk); mode = m; inv = iv; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    guard = 0;
    while (ndone == bd && guard < 3000) begin
      @(posedge clk); #1; guard++;
      if (poke_mid && guard == 300) begin start = 1'b1; mode = ~m; inv = ~iv; end
      if (poke_mid && guard == 301) start = 1'b0;
      if (poke_fin && done) start = 1'b1;
    end
    start = 1'b0;
    if (guard >= 3000) chk("done_timeout", guard, 0);
    mode = m; inv = iv;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int b, bw, bd, g, wsnap, dsnap;

  initial begin
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'({rd_addr_a, rd_addr_b, tw_idx}), 0);
    @(negedge clk); rst = 1'b1;

    // Kyber NTT, with a start pulse in the FIN cycle
    run_xform(1'b0, 1'b0, 1'b0, 1'b1, b, bw, bd);
    chk("t1_k0_a", rec_a[b], 0);
    chk("t1_k0_b", rec_b[b], 128);
    chk("t1_k0_tw", rec_tw[b], 1);
    chk("t1_k127_a", rec_a[b+127], 127);
    chk("t1_k127_b", rec_b[b+127], 255);
    chk("t1_l1k64_layer", rec_l[b+192], 1);
    chk("t1_l1k64_a", rec_a[b+192], 128);
    chk("t1_l1k64_b", rec_b[b+192], 192);
    chk("t1_l1k64_tw", rec_tw[b+192], 3);
    chk("t1_drain_gap", rec_t[b+128] - rec_t[b+127], 8);
    chk("t1_run_len", t_done - rec_t[b], 945);
    chk("t1_reads", nrd - b, 896);
    chk("t1_writes", nwr - bw, 896);
    chk("t1_sel_a", int'(sel_a), 0);
    chk("t1_adder_mode", int'(adder_mode), 0);
    chk("fin_start_busy", int'(busy), 0);
    chk("fin_start_rd_en", int'(rd_en), 0);

    // Kyber INTT
    run_xform(1'b0, 1'b1, 1'b0, 1'b0, b, bw, bd);
    chk("t2_k0", rec_a[b]*65536 + rec_b[b]*256 + rec_tw[b], 0*65536 + 2*256 + 127);
    chk("t2_k1", rec_a[b+1]*65536 + rec_b[b+1]*256 + rec_tw[b+1], 1*65536 + 3*256 + 127);
    chk("t2_k2", rec_a[b+2]*65536 + rec_b[b+2]*256 + rec_tw[b+2], 4*65536 + 6*256 + 126);
    chk("t2_last", rec_a[b+895]*65536 + rec_b[b+895]*256 + rec_tw[b+895], 127*65536 + 255*256 + 1);
    chk("t2_sel_a", int'(sel_a), 2);
    chk("t2_run_len", t_done - rec_t[b], 945);
    chk("t2_writes", nwr - bw, 896);

    // Dilithium NTT
    run_xform(1'b1, 1'b0, 1'b0, 1'b0, b, bw, bd);
    chk("t3_adder_mode", int'(adder_mode), 1);
    chk("t3_l7_layer", rec_l[b+1023], 7);
    chk("t3_l7k127", rec_a[b+1023]*65536 + rec_b[b+1023]*256 + rec_tw[b+1023], 254*65536 + 255*256 + 255);
    chk("t3_run_len", t_done - rec_t[b], 1080);
    chk("t3_reads", nrd - b, 1024);
    chk("t3_writes", nwr - bw, 1024);

    // Kyber NTT with start, mode and inv toggled mid-run
    run_xform(1'b0, 1'b0, 1'b1, 1'b0, b, bw, bd);
    chk("t5_run_len", t_done - rec_t[b], 945);
    chk("t5_reads", nrd - b, 896);
    chk("t5_done_count", ndone - bd, 1);
    chk("t5_sel_a", int'(sel_a), 0);
    chk("t5_adder_mode", int'(adder_mode), 0);
    chk("t5_l1k64_tw", rec_tw[b+192], 3);

    // Dilithium INTT aborted by reset during layer 3
    @(negedge clk); mode = 1'b1; inv = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    g = 0;
    while (layer != 3'd3 && g < 2000) begin @(posedge clk); #1; g++; end
    chk("t6_reach_layer3", int'(layer), 3);
    chk("t6_sel_a_pre", int'(sel_a), 2);
    #1 rst = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_rd_en", int'(rd_en), 0);
    chk("t6_wr_en", int'(wr_en), 0);
    chk("t6_layer", int'(layer), 0);
    chk("t6_addr", int'({rd_addr_a, rd_addr_b, tw_idx}), 0);
    chk("t6_wr_addr", int'({wr_addr_a, wr_addr_b}), 0);
    chk("t6_cfg", int'({sel_a, adder_mode}), 0);
    wsnap = nwr; dsnap = ndone;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (1200) @(posedge clk);
    #1;
    chk("t6_no_writes", nwr - wsnap, 0);
    chk("t6_no_done", ndone - dsnap, 0);

    // Clean Dilithium INTT after the abort
    run_xform(1'b1, 1'b1, 1'b0, 1'b0, b, bw, bd);
    chk("t6_k0", rec_a[b]*65536 + rec_b[b]*256 + rec_tw[b], 0*65536 + 1*256 + 255);
    chk("t6_last", rec_a[b+1023]*65536 + rec_b[b+1023]*256 + rec_tw[b+1023], 127*65536 + 255*256 + 1);
    chk("t6_run_len", t_done - rec_t[b], 1080);
    chk("t6_writes", nwr - bw, 1024);
    chk("t6_sel_a", int'(sel_a), 2);

    chk("write_alignment", align_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
